// File: rtl/al4s3b_wb_host_seq.sv
// rtl/al4s3b_wb_host_seq.sv - single-outstanding request/response to Wishbone master sequencer
// Optional bus-timeout logic (wait counter, rsp_err, err_cnt) is compiled in by WB_HOST_TIMEOUT_EN.
module al4s3b_wb_host_seq #(
   parameter int                   ADDRWIDTH        = 17,
   parameter int                   DATAWIDTH        = 32,
   parameter int                   TIMEOUT_CYCLES   = 255,
   parameter logic [DATAWIDTH-1:0] TIMEOUT_RD_VALUE = 32'hBAD_FAB_AC
) (
   input  logic                 WB_CLK,
   input  logic                 WB_RST,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ADDRWIDTH-1:0] req_adr,
   input  logic [3:0]           req_be,
   input  logic [DATAWIDTH-1:0] req_wdat,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATAWIDTH-1:0] rsp_rdat,
   output logic                 rsp_err,
   output logic [ADDRWIDTH-1:0] WBs_ADR,
   output logic                 WBs_CYC,
   output logic                 WBs_STB,
   output logic                 WBs_WE,
   output logic                 WBs_RD,
   output logic [3:0]           WBs_BYTE_STB,
   output logic [DATAWIDTH-1:0] WBs_WR_DAT,
   input  logic [DATAWIDTH-1:0] WBs_RD_DAT,
   input  logic                 WBs_ACK,
   output logic [7:0]           err_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   w_accept;
   logic                   w_ack_bus;
   logic                   w_timeout;
   logic                   r_cyc;
   logic                   r_we;
   logic [ADDRWIDTH-1:0]   r_adr;
   logic [3:0]             r_be;
   logic [DATAWIDTH-1:0]   r_wdat;
   logic [DATAWIDTH-1:0]   r_rdat;
   logic                   r_err;

   // Gated by reset so a request can never be taken while the block is being cleared.
   assign req_ready = (r_state == S_IDLE) && !WB_RST;
   assign w_accept  = req_valid && req_ready;
   assign w_ack_bus = (r_state == S_BUS) && WBs_ACK;

`ifdef WB_HOST_TIMEOUT_EN
   localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_wait;
   logic [7:0] r_err_cnt;

   // ACK has priority: a timeout only fires on a BUS cycle without ACK.
   assign w_timeout = (r_state == S_BUS) && !WBs_ACK && (r_wait == LP_WAIT_LAST);

   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         r_wait    <= 8'd0;
         r_err_cnt <= 8'd0;
      end else begin
         if (w_accept) begin
            r_wait <= 8'd0;
         end else if ((r_state == S_BUS) && !WBs_ACK) begin
            r_wait <= r_wait + 8'd1;
         end
         if (w_timeout && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign err_cnt = r_err_cnt;
   assign rsp_err = r_err;
`else
   assign w_timeout = 1'b0;
   assign err_cnt   = 8'd0;
   assign rsp_err   = 1'b0;
`endif

   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = S_BUS;
         S_BUS:  if (w_ack_bus || w_timeout) w_next = S_RESP;
         S_RESP: if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         r_cyc  <= 1'b0;
         r_we   <= 1'b0;
         r_adr  <= '0;
         r_be   <= 4'd0;
         r_wdat <= '0;
         r_rdat <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cyc  <= 1'b1;
            r_we   <= req_we;
            r_adr  <= req_adr;
            r_be   <= req_be;
            r_wdat <= req_wdat;
         end else if (w_ack_bus) begin
            r_cyc  <= 1'b0;
            r_rdat <= r_we ? '0 : WBs_RD_DAT;
            r_err  <= 1'b0;
         end else if (w_timeout) begin
            r_cyc  <= 1'b0;
            r_rdat <= TIMEOUT_RD_VALUE;
            r_err  <= 1'b1;
         end
      end
   end

   // Address/strobe/data stay registered after BUS; only the cycle qualifiers drop.
   assign WBs_CYC      = r_cyc;
   assign WBs_STB      = r_cyc;
   assign WBs_WE       = r_cyc && r_we;
   assign WBs_RD       = r_cyc && !r_we;
   assign WBs_ADR      = r_adr;
   assign WBs_BYTE_STB = r_be;
   assign WBs_WR_DAT   = r_wdat;
   assign rsp_valid    = (r_state == S_RESP);
   assign rsp_rdat     = r_rdat;

endmodule

// File: tb/tb_al4s3b_wb_host_seq.sv
// tb/tb_al4s3b_wb_host_seq.sv - directed self-checking bench for al4s3b_wb_host_seq
module tb_al4s3b_wb_host_seq;

   logic        WB_CLK;
   logic        WB_RST;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [16:0] req_adr;
   logic [3:0]  req_be;
   logic [31:0] req_wdat;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdat;
   logic        rsp_err;
   logic [16:0] WBs_ADR;
   logic        WBs_CYC;
   logic        WBs_STB;
   logic        WBs_WE;
   logic        WBs_RD;
   logic [3:0]  WBs_BYTE_STB;
   logic [31:0] WBs_WR_DAT;
   logic [31:0] WBs_RD_DAT;
   logic        WBs_ACK;
   logic [7:0]  err_cnt;

   int total;
   int bad;

   al4s3b_wb_host_seq #(
      .ADDRWIDTH       (17),
      .DATAWIDTH       (32),
      .TIMEOUT_CYCLES  (4),
      .TIMEOUT_RD_VALUE(32'hBAD_FAB_AC)
   ) dut (
      .WB_CLK      (WB_CLK),
      .WB_RST      (WB_RST),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_adr     (req_adr),
      .req_be      (req_be),
      .req_wdat    (req_wdat),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdat    (rsp_rdat),
      .rsp_err     (rsp_err),
      .WBs_ADR     (WBs_ADR),
      .WBs_CYC     (WBs_CYC),
      .WBs_STB     (WBs_STB),
      .WBs_WE      (WBs_WE),
      .WBs_RD      (WBs_RD),
      .WBs_BYTE_STB(WBs_BYTE_STB),
      .WBs_WR_DAT  (WBs_WR_DAT),
      .WBs_RD_DAT  (WBs_RD_DAT),
      .WBs_ACK     (WBs_ACK),
      .err_cnt     (err_cnt)
   );

   initial WB_CLK = 1'b0;
   always #5 WB_CLK = ~WB_CLK;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one request and plays the slave; ack_wait = BUS cycles without ACK before ACK, -1 = never.
   task automatic run_txn(input logic we, input logic [16:0] adr, input logic [3:0] be,
                          input logic [31:0] wdat, input int ack_wait, input logic [31:0] rdat,
                          output int cyc_n, output logic seen, output logic [31:0] rd,
                          output logic er, output logic stable_ok);
      cyc_n = 0; seen = 1'b0; rd = '0; er = 1'b0; stable_ok = 1'b1;
      @(negedge WB_CLK);
      req_valid = 1'b1; req_we = we; req_adr = adr; req_be = be; req_wdat = wdat;
      rsp_ready = 1'b0; WBs_ACK = 1'b0; WBs_RD_DAT = rdat;
      @(negedge WB_CLK);
      req_valid = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (rsp_valid) begin
            seen = 1'b1; rd = rsp_rdat; er = rsp_err;
            if (WBs_CYC || WBs_STB) stable_ok = 1'b0;
            break;
         end
         if (WBs_CYC) begin
            cyc_n++;
            if (WBs_ADR !== adr || WBs_BYTE_STB !== be || WBs_WR_DAT !== wdat ||
                WBs_WE !== we || WBs_RD !== ~we || WBs_STB !== 1'b1 || req_ready !== 1'b0)
               stable_ok = 1'b0;
         end
         WBs_ACK = (ack_wait >= 0) && (cyc_n == ack_wait + 1);
         @(negedge WB_CLK);
      end
      WBs_ACK = 1'b0;
      if (seen) begin
         rsp_ready = 1'b1;
         @(negedge WB_CLK);
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      WB_RST = 1'b1;
      repeat (3) @(negedge WB_CLK);
      total++;
      if ({rsp_valid, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT,
           rsp_rdat, rsp_err, err_cnt} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got cyc=%b rv=%b adr=%h rdat=%h err_cnt=%h, required all zero",
                  WBs_CYC, rsp_valid, WBs_ADR, rsp_rdat, err_cnt);
      end
      total++;
      if (req_ready !== 1'b0) begin
         bad++; $display("FAIL reset_req_ready: got %b required 0", req_ready);
      end
      WB_RST = 1'b0;
      @(negedge WB_CLK);
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL post_reset_req_ready: got %b required 1", req_ready);
      end
   endtask

   task automatic test_read;
      int cn; logic s, e, ok; logic [31:0] d;
      run_txn(1'b0, 17'h00000, 4'hF, 32'h0, 1, 32'h1234_5678, cn, s, d, e, ok);
      total++;
      if (cn !== 2) begin bad++; $display("FAIL read_cyc_cycles: got %0d required 2", cn); end
      total++;
      if (s !== 1'b1 || ok !== 1'b1) begin bad++; $display("FAIL read_protocol: seen=%b stable=%b required 1 1", s, ok); end
      total++;
      if (d !== 32'h1234_5678 || e !== 1'b0) begin
         bad++; $display("FAIL read_rsp: got rdat=%h err=%b required 12345678 0", d, e);
      end
      run_txn(1'b0, 17'h1_0ABC, 4'h5, 32'h0, 3, 32'hA5A5_0F0F, cn, s, d, e, ok);
      total++;
      if (cn !== 4 || s !== 1'b1 || ok !== 1'b1 || d !== 32'hA5A5_0F0F || e !== 1'b0) begin
         bad++; $display("FAIL read_wait3: got cyc=%0d seen=%b stable=%b rdat=%h err=%b required 4 1 1 a5a50f0f 0",
                         cn, s, ok, d, e);
      end
   endtask

   task automatic test_write;
      int cn; logic s, e, ok; logic [31:0] d;
      run_txn(1'b1, 17'h00008, 4'hF, 32'h0000_0001, 0, 32'hDEAD_BEEF, cn, s, d, e, ok);
      total++;
      if (cn !== 1) begin bad++; $display("FAIL write_cyc_cycles: got %0d required 1", cn); end
      total++;
      if (s !== 1'b1 || ok !== 1'b1) begin bad++; $display("FAIL write_protocol: seen=%b stable=%b required 1 1", s, ok); end
      total++;
      if (d !== 32'h0 || e !== 1'b0) begin
         bad++; $display("FAIL write_rsp: got rdat=%h err=%b required 00000000 0", d, e);
      end
   endtask

   task automatic test_hold;
      @(negedge WB_CLK);
      req_valid = 1'b1; req_we = 1'b0; req_adr = 17'h00010; req_be = 4'h3; req_wdat = '0;
      rsp_ready = 1'b0; WBs_ACK = 1'b0;
      @(negedge WB_CLK);
      WBs_ACK = 1'b1; WBs_RD_DAT = 32'hCAFE_F00D;
      @(negedge WB_CLK);
      WBs_ACK = 1'b0; WBs_RD_DAT = 32'h0;
      for (int i = 0; i < 10; i++) begin
         total++;
         if (rsp_valid !== 1'b1 || rsp_rdat !== 32'hCAFE_F00D || rsp_err !== 1'b0) begin
            bad++; $display("FAIL hold_rsp[%0d]: got valid=%b rdat=%h err=%b required 1 cafef00d 0",
                            i, rsp_valid, rsp_rdat, rsp_err);
         end
         total++;
         if (req_ready !== 1'b0 || WBs_CYC !== 1'b0) begin
            bad++; $display("FAIL hold_bus[%0d]: got req_ready=%b cyc=%b required 0 0", i, req_ready, WBs_CYC);
         end
         @(negedge WB_CLK);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge WB_CLK);
      rsp_ready = 1'b0;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL hold_release: got valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_back_to_back;
      int n_cyc; int n_rsp;
      n_cyc = 0; n_rsp = 0;
      @(negedge WB_CLK);
      req_valid = 1'b1; req_we = 1'b0; req_adr = 17'h00004; req_be = 4'hF; req_wdat = '0;
      rsp_ready = 1'b1; WBs_ACK = 1'b1; WBs_RD_DAT = 32'h0BAD_CAFE;
      for (int i = 0; i < 9; i++) begin
         @(negedge WB_CLK);
         if (WBs_CYC) n_cyc++;
         if (rsp_valid) begin
            n_rsp++;
            total++;
            if (rsp_rdat !== 32'h0BAD_CAFE) begin
               bad++; $display("FAIL b2b_rdat: got %h required 0badcafe", rsp_rdat);
            end
         end
      end
      req_valid = 1'b0;
      total++;
      if (n_cyc !== 3 || n_rsp !== 3) begin
         bad++; $display("FAIL b2b_throughput: got cyc=%0d rsp=%0d in 9 cycles required 3 3", n_cyc, n_rsp);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge WB_CLK);
         total++;
         if (WBs_CYC !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL idle_ack_ignored[%0d]: got cyc=%b valid=%b required 0 0", i, WBs_CYC, rsp_valid);
         end
      end
      WBs_ACK = 1'b0; rsp_ready = 1'b0;
   endtask

`ifdef WB_HOST_TIMEOUT_EN
   task automatic test_timeout;
      int cn; logic s, e, ok; logic [31:0] d;
      run_txn(1'b0, 17'h00020, 4'hF, 32'h0, -1, 32'h1111_1111, cn, s, d, e, ok);
      total++;
      if (cn !== 4 || s !== 1'b1 || ok !== 1'b1) begin
         bad++; $display("FAIL timeout_cycles: got cyc=%0d seen=%b stable=%b required 4 1 1", cn, s, ok);
      end
      total++;
      if (e !== 1'b1 || d !== 32'hBAD_FAB_AC || err_cnt !== 8'd1) begin
         bad++; $display("FAIL timeout_rsp: got err=%b rdat=%h err_cnt=%h required 1 badfabac 01", e, d, err_cnt);
      end
      run_txn(1'b0, 17'h00024, 4'hF, 32'h0, 3, 32'h7777_8888, cn, s, d, e, ok);
      total++;
      if (cn !== 4 || e !== 1'b0 || d !== 32'h7777_8888 || err_cnt !== 8'd1) begin
         bad++; $display("FAIL ack_at_limit: got cyc=%0d err=%b rdat=%h err_cnt=%h required 4 0 77778888 01",
                         cn, e, d, err_cnt);
      end
      for (int k = 0; k < 299; k++) begin
         run_txn(1'b0, 17'h00028, 4'hF, 32'h0, -1, 32'h0, cn, s, d, e, ok);
         if (k == 253) begin
            total++;
            if (err_cnt !== 8'hFF) begin bad++; $display("FAIL err_cnt_255: got %h required ff", err_cnt); end
         end
      end
      total++;
      if (err_cnt !== 8'hFF) begin bad++; $display("FAIL err_cnt_saturate: got %h required ff", err_cnt); end
   endtask
`else
   task automatic test_timeout;
      int cn; logic s, e, ok; logic [31:0] d;
      run_txn(1'b0, 17'h00020, 4'hF, 32'h0, 300, 32'h1357_9BDF, cn, s, d, e, ok);
      total++;
      if (cn !== 301 || s !== 1'b1 || ok !== 1'b1) begin
         bad++; $display("FAIL long_wait_cycles: got cyc=%0d seen=%b stable=%b required 301 1 1", cn, s, ok);
      end
      total++;
      if (e !== 1'b0 || d !== 32'h1357_9BDF || err_cnt !== 8'd0) begin
         bad++; $display("FAIL long_wait_rsp: got err=%b rdat=%h err_cnt=%h required 0 13579bdf 00", e, d, err_cnt);
      end
   endtask
`endif

   task automatic test_reset_mid_bus;
      @(negedge WB_CLK);
      req_valid = 1'b1; req_we = 1'b1; req_adr = 17'h1FFFF; req_be = 4'hA; req_wdat = 32'hFFFF_FFFF;
      rsp_ready = 1'b0; WBs_ACK = 1'b0;
      @(negedge WB_CLK);
      req_valid = 1'b0;
      total++;
      if (WBs_CYC !== 1'b1 || WBs_WE !== 1'b1) begin
         bad++; $display("FAIL mid_bus_setup: got cyc=%b we=%b required 1 1", WBs_CYC, WBs_WE);
      end
      WB_RST = 1'b1;
      @(negedge WB_CLK);
      total++;
      if ({rsp_valid, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT,
           rsp_rdat, rsp_err, err_cnt, req_ready} !== '0) begin
         bad++; $display("FAIL mid_bus_reset: got cyc=%b adr=%h be=%h wdat=%h err_cnt=%h req_ready=%b required all zero",
                         WBs_CYC, WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT, err_cnt, req_ready);
      end
      WB_RST = 1'b0;
      @(negedge WB_CLK);
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_bus_ready: got %b required 1", req_ready); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rsp_valid !== 1'b0 || WBs_CYC !== 1'b0) begin
            bad++; $display("FAIL mid_bus_no_rsp[%0d]: got valid=%b cyc=%b required 0 0", i, rsp_valid, WBs_CYC);
         end
         @(negedge WB_CLK);
      end
   endtask

   initial begin
      total = 0; bad = 0;
      WB_RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_be = '0; req_wdat = '0;
      rsp_ready = 1'b0; WBs_RD_DAT = '0; WBs_ACK = 1'b0;
      test_reset();
      test_read();
      test_write();
      test_hold();
      test_back_to_back();
      test_timeout();
      test_reset_mid_bus();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/al4s3b_wb_host_seq.md
AL4S3B_WB_HOST_SEQ -- requirements
Module: al4s3b_wb_host_seq

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 17, Wishbone byte-address width.
REQ-002 SHALL have parameter DATAWIDTH, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waiting for WBs_ACK; legal range 1..255.
REQ-004 SHALL have parameter TIMEOUT_RD_VALUE, default 32'hBAD_FAB_AC, rsp_rdata on timeout.
REQ-005 SHALL use a single clock and a synchronous, active-high reset: WB_CLK input 1, FPGA clock; WB_RST input 1, synchronous active-high reset.
REQ-006 SHALL have ports:
- req_valid in 1, request present.
- req_ready out 1, request accepted when high with req_valid.
- req_we in 1, 1 = write.
- req_adr in ADDRWIDTH, byte address.
- req_be in 4, byte strobes.
- req_wdat in DATAWIDTH, write data.
- rsp_valid out 1, response present.
- rsp_ready in 1, response consumed.
- rsp_rdat out DATAWIDTH, read data.
- rsp_err out 1, timeout flag.
- WBs_ADR out 17; WBs_CYC out 1; WBs_STB out 1; WBs_WE out 1; WBs_RD out 1; WBs_BYTE_STB out 4; WBs_WR_DAT out 32.
- WBs_RD_DAT in 32; WBs_ACK in 1.
- err_cnt out 8, saturating timeout count.

Function
REQ-007 SHALL implement FSM states IDLE, BUS, RESP; one transaction outstanding at a time.
REQ-008 req_ready SHALL be 1 only in IDLE.
REQ-009 IDLE->BUS on req_valid&req_ready; SHALL register adr/be/we/wdat in the same edge.
REQ-010 In BUS, WBs_CYC=WBs_STB=1 from the cycle after acceptance; WBs_WE=req_we, WBs_RD=~req_we; ADR/BYTE_STB/WR_DAT SHALL be held stable for the whole of BUS.
REQ-011 ACK sampled high in BUS SHALL cause BUS->RESP next edge; CYC/STB/WE/RD SHALL drop in that same edge, so a zero-wait slave gives exactly one cycle of CYC/STB.
REQ-012 On ACK of a read, rsp_rdat SHALL capture WBs_RD_DAT; on a write, rsp_rdat SHALL be 0; rsp_err=0.
REQ-013 rsp_valid SHALL be 1 exactly in RESP; RESP->IDLE on rsp_ready; rsp_rdat/rsp_err SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-014 WBs_ACK outside BUS SHALL be ignored.
REQ-015 Minimum throughput SHALL be one transaction per 3 cycles (IDLE, BUS, RESP) with rsp_ready tied high.
REQ-016 Wait counter SHALL clear on entry to BUS and increment each BUS cycle without ACK.
REQ-017 Counter reaching TIMEOUT_CYCLES without ACK SHALL force BUS->RESP with rsp_err=1 and rsp_rdat=TIMEOUT_RD_VALUE, and CYC/STB dropped.
REQ-018 ACK in the same cycle the counter reaches TIMEOUT_CYCLES: ACK SHALL win, with rsp_err=0 and no err_cnt increment.
REQ-019 err_cnt SHALL increment by 1 per timeout and saturate at 8'hFF without wrapping.

Reset
REQ-020 WB_RST high at any clock edge SHALL force IDLE, with rsp_valid=0, WBs_CYC=WBs_STB=WBs_WE=WBs_RD=0, WBs_ADR=0, WBs_BYTE_STB=0, WBs_WR_DAT=0, rsp_rdat=0, rsp_err=0, err_cnt=0, wait counter 0.
REQ-021 Reset asserted mid-BUS SHALL abort the cycle with no response generated; req_ready SHALL be 0 while WB_RST=1 and 1 in the first cycle after it deasserts.

Configuration
REQ-022 Macro WB_HOST_TIMEOUT_EN defined: timeout logic per REQ-016..019 is compiled in.
REQ-023 Macro WB_HOST_TIMEOUT_EN undefined: no wait counter, BUS waits indefinitely for ACK, rsp_err and err_cnt SHALL be tied to 0.

Verification
REQ-024 Read to 17'h00000, slave ACKs 1 cycle after STB with RD_DAT=32'h1234_5678 -> CYC/STB high 2 cycles, rsp_valid next cycle, rsp_rdat=32'h1234_5678, rsp_err=0.
REQ-025 Write 17'h00008, be=4'hF, wdat=32'h0000_0001, zero-wait ACK -> exactly 1 cycle CYC/STB/WE, WBs_RD=0, rsp_rdat=0.
REQ-026 (TIMEOUT_EN, TIMEOUT_CYCLES=4) Slave never ACKs -> CYC drops after 4 BUS cycles, rsp_err=1, rsp_rdat=32'hBAD_FAB_AC, err_cnt=1; 300 such timeouts -> err_cnt=8'hFF.
REQ-027 (TIMEOUT_EN, TIMEOUT_CYCLES=4) ACK coincident with the 4th BUS cycle -> rsp_err=0, read data returned, err_cnt unchanged.
REQ-028 rsp_ready held low 10 cycles after a response -> rsp_valid/rsp_rdat stable, req_ready=0, no new CYC.
REQ-029 WB_RST pulsed for 1 cycle during BUS -> all outputs at reset values the next cycle, no rsp_valid, req_ready=1 the cycle after reset deasserts.
